granth_crc_engine: RTL and testbench

Parametrised, nibble-serial CRC engine and the successor to the fixed-64-bit CRC decelerator setup FSM. It accepts a runtime CRC configuration stream (width 3..MAX_WIDTH, poly, init, xor, reflect flags), absorbs message bytes one bit per cycle, and streams the finished CRC out byte-serially. It sits directly behind the 8-bit TinyTapeout pin mux.

---
 rtl/granth_crc_engine.sv | 272 +++++++++++++++++++++++++++
 tb/tb_granth_crc_engine.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/granth_crc_engine.sv
// granth_crc_engine: runtime-configurable nibble-serial CRC engine behind an 8-bit pin mux.
// Build option GRANTH_CRC_FAST_EN: absorb 4 message bits per cycle instead of 1.
module granth_crc_engine #(
   parameter int unsigned MAX_WIDTH = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] cmd,
   input  logic [3:0] data_in,
   output logic       cfg_active,
   output logic       cfg_err,
   output logic       busy,
   output logic       overrun,
   output logic       crc_valid,
   output logic       crc_last,
   output logic [7:0] crc_byte
);

   localparam int unsigned IdxW   = $clog2(MAX_WIDTH);
   localparam int unsigned NumNib = MAX_WIDTH / 4;
`ifdef GRANTH_CRC_FAST_EN
   localparam int unsigned BitsPerCyc = 4;
`else
   localparam int unsigned BitsPerCyc = 1;
`endif
   localparam int unsigned BusyCyc = 8 / BitsPerCyc;

   localparam logic [IdxW-1:0]      DefWm1  = IdxW'((MAX_WIDTH >= 32) ? 31 : MAX_WIDTH - 1);
   localparam logic [MAX_WIDTH-1:0] DefPoly = MAX_WIDTH'(64'h0000_0000_04C1_1DB7);
   localparam logic [MAX_WIDTH-1:0] DefOnes = MAX_WIDTH'(64'h0000_0000_FFFF_FFFF);

   localparam logic [1:0] CmdReset   = 2'd0;
   localparam logic [1:0] CmdSetup   = 2'd1;
   localparam logic [1:0] CmdMessage = 2'd2;
   localparam logic [1:0] CmdFinal   = 2'd3;

   // config_lo is taken on the idle cycle that samples SETUP, so the stream continues in StCfgHi
   typedef enum logic [2:0] {StIdle, StCfgHi, StPoly, StInit, StXor} state_e;

   state_e               state_q, state_d;
   logic [3:0]           nib_cnt_q, nib_cnt_d;
   logic [5:0]           wn_q, wn_d;
   logic                 new_rin_q, new_rin_d, new_rout_q, new_rout_d, new_ok_q, new_ok_d;
   logic [IdxW-1:0]      wm1_q, wm1_d;
   logic                 rin_q, rin_d, rout_q, rout_d;
   logic [MAX_WIDTH-1:0] poly_q, poly_d, init_q, init_d, xor_q, xor_d, acc_q, acc_d;
   logic                 cfg_active_q, cfg_active_d, cfg_err_q, cfg_err_d;
   logic                 busy_q, busy_d, overrun_q, overrun_d;
   logic [2:0]           bcnt_q, bcnt_d;
   logic [7:0]           byte_q, byte_d;
   logic                 lo_pend_q, lo_pend_d;
   logic [3:0]           lo_nib_q, lo_nib_d;
   logic                 crc_valid_q, crc_valid_d, crc_last_q, crc_last_d;
   logic [7:0]           crc_byte_q, crc_byte_d;
   logic [2:0]           out_idx_q, out_idx_d;

   logic [MAX_WIDTH-1:0] cur_mask, new_mask, acc_rev, result, acc_step;
   logic [7:0]           byte_step, byte_in, byte_rev;
   logic [5:0]           wn_new;
   logic [2:0]           last_idx;
   logic                 fb;

   function automatic logic [MAX_WIDTH-1:0] put_nib(input logic [MAX_WIDTH-1:0] v,
                                                     input logic [3:0] idx,
                                                     input logic [3:0] nib);
      logic [MAX_WIDTH-1:0] r;
      r = v;
      for (int i = 0; i < NumNib; i++) begin
         if (idx == 4'(i)) r[4*i +: 4] = nib;
      end
      return r;
   endfunction

   always_comb begin
      cur_mask = {MAX_WIDTH{1'b1}} >> (IdxW'(MAX_WIDTH - 1) - wm1_q);
      new_mask = {MAX_WIDTH{1'b1}} >> (IdxW'(MAX_WIDTH - 1) - wn_q[IdxW-1:0]);
      acc_rev  = '0;
      for (int i = 0; i < MAX_WIDTH; i++) acc_rev[i] = acc_q[MAX_WIDTH-1-i];
      result   = (rout_q ? (acc_rev >> (IdxW'(MAX_WIDTH - 1) - wm1_q)) : acc_q) ^ xor_q;
      last_idx = 3'(wm1_q >> 3);
      byte_in  = {data_in, lo_nib_q};
      byte_rev = '0;
      for (int i = 0; i < 8; i++) byte_rev[i] = byte_in[7-i];
   end

   // Message byte is always held MSB-first; reflect_in is applied when it is loaded.
   always_comb begin
      acc_step  = acc_q;
      byte_step = byte_q;
      fb        = 1'b0;
      for (int k = 0; k < BitsPerCyc; k++) begin
         fb        = acc_step[wm1_q] ^ byte_step[7];
         acc_step  = ((acc_step << 1) & cur_mask) ^ (fb ? poly_q : '0);
         byte_step = byte_step << 1;
      end
   end

   always_comb begin
      state_d     = state_q;
      nib_cnt_d   = nib_cnt_q;
      wn_d        = wn_q;
      new_rin_d   = new_rin_q;
      new_rout_d  = new_rout_q;
      new_ok_d    = new_ok_q;
      wm1_d       = wm1_q;
      rin_d       = rin_q;
      rout_d      = rout_q;
      poly_d      = poly_q;
      init_d      = init_q;
      xor_d       = xor_q;
      acc_d       = acc_q;
      cfg_err_d   = cfg_err_q;
      busy_d      = busy_q;
      overrun_d   = overrun_q;
      bcnt_d      = bcnt_q;
      byte_d      = byte_q;
      lo_pend_d   = lo_pend_q;
      lo_nib_d    = lo_nib_q;
      crc_valid_d = 1'b0;
      crc_last_d  = 1'b0;
      crc_byte_d  = 8'h00;
      out_idx_d   = 3'd0;
      wn_new      = {data_in[3:2], wn_q[3:0]} - 6'd1;

      unique case (state_q)
         StIdle: begin
            if (busy_q) begin
               acc_d  = acc_step;
               byte_d = byte_step;
               bcnt_d = bcnt_q + 3'd1;
               if (bcnt_q == 3'(BusyCyc - 1)) busy_d = 1'b0;
               if (cmd == CmdMessage) overrun_d = 1'b1;
            end else begin
               if (cmd != CmdMessage) lo_pend_d = 1'b0;
               unique case (cmd)
                  CmdReset: begin
                     acc_d     = init_q;
                     overrun_d = 1'b0;
                  end
                  CmdSetup: begin
                     state_d = StCfgHi;
                     wn_d    = {2'b00, data_in};
                  end
                  CmdMessage: begin
                     if (!lo_pend_q) begin
                        lo_nib_d  = data_in;
                        lo_pend_d = 1'b1;
                     end else begin
                        byte_d    = rin_q ? byte_rev : byte_in;
                        busy_d    = 1'b1;
                        bcnt_d    = 3'd0;
                        lo_pend_d = 1'b0;
                     end
                  end
                  CmdFinal: begin
                     crc_valid_d = 1'b1;
                     crc_byte_d  = 8'(result >> {out_idx_q, 3'b000});
                     crc_last_d  = (out_idx_q == last_idx);
                     out_idx_d   = (out_idx_q == last_idx) ? 3'd0 : out_idx_q + 3'd1;
                  end
                  default: ;
               endcase
            end
         end
         StCfgHi: begin
            // wn holds width-1; a width code of 0 wraps to 63, i.e. 64 bits
            wn_d       = wn_new;
            new_rin_d  = data_in[0];
            new_rout_d = data_in[1];
            new_ok_d   = (wn_new >= 6'd2) && (wn_new <= 6'(MAX_WIDTH - 1));
            nib_cnt_d  = 4'd0;
            state_d    = StPoly;
         end
         StPoly, StInit, StXor: begin
            if (new_ok_q) begin
               if (state_q == StPoly) poly_d = put_nib(poly_q, nib_cnt_q, data_in);
               if (state_q == StInit) init_d = put_nib(init_q, nib_cnt_q, data_in);
               if (state_q == StXor)  xor_d  = put_nib(xor_q, nib_cnt_q, data_in);
            end
            nib_cnt_d = nib_cnt_q + 4'd1;
            if (nib_cnt_q == wn_q[5:2]) begin
               nib_cnt_d = 4'd0;
               unique case (state_q)
                  StPoly:  state_d = StInit;
                  StInit:  state_d = StXor;
                  default: begin
                     state_d   = StIdle;
                     cfg_err_d = !new_ok_q;
                     if (new_ok_q) begin
                        wm1_d  = wn_q[IdxW-1:0];
                        rin_d  = new_rin_q;
                        rout_d = new_rout_q;
                        poly_d = poly_q & new_mask;
                        init_d = init_q & new_mask;
                        xor_d  = xor_d & new_mask;
                        acc_d  = init_q & new_mask;
                     end
                  end
               endcase
            end
         end
         default: state_d = StIdle;
      endcase

      cfg_active_d = (state_d != StIdle) || (state_q != StIdle);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         nib_cnt_q    <= '0;
         wn_q         <= '0;
         new_rin_q    <= 1'b0;
         new_rout_q   <= 1'b0;
         new_ok_q     <= 1'b0;
         wm1_q        <= DefWm1;
         rin_q        <= 1'b0;
         rout_q       <= 1'b0;
         poly_q       <= DefPoly;
         init_q       <= DefOnes;
         xor_q        <= DefOnes;
         acc_q        <= DefOnes;
         cfg_active_q <= 1'b0;
         cfg_err_q    <= 1'b0;
         busy_q       <= 1'b0;
         overrun_q    <= 1'b0;
         bcnt_q       <= '0;
         byte_q       <= '0;
         lo_pend_q    <= 1'b0;
         lo_nib_q     <= '0;
         crc_valid_q  <= 1'b0;
         crc_last_q   <= 1'b0;
         crc_byte_q   <= '0;
         out_idx_q    <= '0;
      end else begin
         state_q      <= state_d;
         nib_cnt_q    <= nib_cnt_d;
         wn_q         <= wn_d;
         new_rin_q    <= new_rin_d;
         new_rout_q   <= new_rout_d;
         new_ok_q     <= new_ok_d;
         wm1_q        <= wm1_d;
         rin_q        <= rin_d;
         rout_q       <= rout_d;
         poly_q       <= poly_d;
         init_q       <= init_d;
         xor_q        <= xor_d;
         acc_q        <= acc_d;
         cfg_active_q <= cfg_active_d;
         cfg_err_q    <= cfg_err_d;
         busy_q       <= busy_d;
         overrun_q    <= overrun_d;
         bcnt_q       <= bcnt_d;
         byte_q       <= byte_d;
         lo_pend_q    <= lo_pend_d;
         lo_nib_q     <= lo_nib_d;
         crc_valid_q  <= crc_valid_d;
         crc_last_q   <= crc_last_d;
         crc_byte_q   <= crc_byte_d;
         out_idx_q    <= out_idx_d;
      end
   end

   assign cfg_active = cfg_active_q;
   assign cfg_err    = cfg_err_q;
   assign busy       = busy_q;
   assign overrun    = overrun_q;
   assign crc_valid  = crc_valid_q;
   assign crc_last   = crc_last_q;
   assign crc_byte   = crc_byte_q;

endmodule

// File: tb/tb_granth_crc_engine.sv
// Testbench for granth_crc_engine: known-answer table, corner sequences, randomized configs
// checked against a bit-serial CRC reference model. Honours GRANTH_CRC_FAST_EN for busy length.
module tb_granth_crc_engine;

`ifdef GRANTH_CRC_FAST_EN
   localparam int BusyCyc = 2;
`else
   localparam int BusyCyc = 8;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] cmd;
   logic [3:0] data_in;
   logic       cfg_active, cfg_err, busy, overrun, crc_valid, crc_last;
   logic [7:0] crc_byte;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] msg[$];

   typedef struct {
      bit          do_setup;
      int          w;
      logic [63:0] poly;
      logic [63:0] init;
      logic [63:0] xo;
      bit          rin;
      bit          rout;
      logic [63:0] expect_crc;
   } vec_t;

   always #5 clk = ~clk;

   granth_crc_engine #(.MAX_WIDTH(64)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd        (cmd),
      .data_in    (data_in),
      .cfg_active (cfg_active),
      .cfg_err    (cfg_err),
      .busy       (busy),
      .overrun    (overrun),
      .crc_valid  (crc_valid),
      .crc_last   (crc_last),
      .crc_byte   (crc_byte)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: spec's per-bit shift rule over the message bit stream, then reflect and xor.
   function automatic logic [63:0] crc_model(input int w, input logic [63:0] poly,
                                             input logic [63:0] init, input logic [63:0] xo,
                                             input bit rin, input bit rout);
      logic [63:0] mask, acc, r;
      logic        b, top;
      mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      acc  = init & mask;
      foreach (msg[j]) begin
         for (int i = 0; i < 8; i++) begin
            b   = rin ? msg[j][i] : msg[j][7-i];
            top = acc[w-1];
            acc = ((acc << 1) & mask) ^ ((top ^ b) ? (poly & mask) : 64'd0);
         end
      end
      if (rout) begin
         r = '0;
         for (int i = 0; i < w; i++) r[i] = acc[w-1-i];
         acc = r;
      end
      return (acc ^ xo) & mask;
   endfunction

   task automatic do_setup(input int w, input logic [63:0] poly, input logic [63:0] init,
                           input logic [63:0] xo, input bit rin, input bit rout);
      logic [5:0]  wc;
      logic [3:0]  nibs[$];
      int          weff, n, act_cnt;
      wc   = 6'(w);
      weff = (wc == 6'd0) ? 64 : int'(wc);
      n    = (weff + 3) / 4;
      nibs = {};
      nibs.push_back(wc[3:0]);
      nibs.push_back({wc[5], wc[4], rout, rin});
      for (int i = 0; i < n; i++) nibs.push_back(poly[4*i +: 4]);
      for (int i = 0; i < n; i++) nibs.push_back(init[4*i +: 4]);
      for (int i = 0; i < n; i++) nibs.push_back(xo[4*i +: 4]);
      act_cnt = 0;
      foreach (nibs[k]) begin
         cmd     = (k == 0) ? 2'd1 : 2'd0;
         data_in = nibs[k];
         tick();
         if (cfg_active === 1'b1) act_cnt++;
      end
      check("cfg_active_len", 64'(act_cnt), 64'(2 + 3 * n));
      cmd = 2'd0;
      tick();
      check("cfg_active_end", 64'(cfg_active), 64'd0);
   endtask

   task automatic send_msg();
      int cnt;
      foreach (msg[j]) begin
         cmd     = 2'd2;
         data_in = msg[j][3:0];
         tick();
         data_in = msg[j][7:4];
         tick();
         cmd = 2'd3;
         cnt = 0;
         while (busy === 1'b1 && cnt < 20) begin
            cnt++;
            tick();
         end
         check("busy_len", 64'(cnt), 64'(BusyCyc));
      end
   endtask

   task automatic read_final(input logic [63:0] exp, input int m);
      int idx;
      cmd = 2'd3;
      for (int k = 0; k <= m; k++) begin
         tick();
         idx = k % m;
         check("crc_valid", 64'(crc_valid), 64'd1);
         check("crc_byte", 64'(crc_byte), 64'((exp >> (8 * idx)) & 64'hFF));
         check("crc_last", 64'(crc_last), 64'(idx == m - 1));
      end
      cmd = 2'd0;
      tick();
      check("crc_valid_fall", 64'(crc_valid), 64'd0);
   endtask

   task automatic load_check_string();
      msg = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[4];
      logic [63:0] exp, rp, ri, rx;
      int          w, len;
      bit          rin, rout;

      tbl[0] = '{1'b0, 32, 64'h04C11DB7, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b0, 1'b0, 64'hFC891918};
      tbl[1] = '{1'b1,  8, 64'h07, 64'h0, 64'h0, 1'b0, 1'b0, 64'hF4};
      tbl[2] = '{1'b1, 16, 64'h8005, 64'h0, 64'h0, 1'b1, 1'b1, 64'hBB3D};
      tbl[3] = '{1'b1,  5, 64'h05, 64'h1F, 64'h1F, 1'b1, 1'b1, 64'h19};

      rst_n   = 1'b0;
      cmd     = 2'd0;
      data_in = 4'h0;
      tick();
      tick();
      check("rst_cfg_active", 64'(cfg_active), 64'd0);
      check("rst_cfg_err", 64'(cfg_err), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_overrun", 64'(overrun), 64'd0);
      check("rst_crc_valid", 64'(crc_valid), 64'd0);
      check("rst_crc_last", 64'(crc_last), 64'd0);
      check("rst_crc_byte", 64'(crc_byte), 64'd0);
      rst_n = 1'b1;

      // Invalid width: stream consumed, error flagged, CRC-32 defaults kept (table row 0)
      do_setup(1, 64'hA, 64'hB, 64'hC, 1'b1, 1'b1);
      check("cfg_err_set", 64'(cfg_err), 64'd1);

      for (int i = 0; i < 4; i++) begin
         if (tbl[i].do_setup) begin
            do_setup(tbl[i].w, tbl[i].poly, tbl[i].init, tbl[i].xo, tbl[i].rin, tbl[i].rout);
            check("cfg_err_clear", 64'(cfg_err), 64'd0);
         end else begin
            cmd = 2'd0;
            tick();
         end
         load_check_string();
         send_msg();
         read_final(tbl[i].expect_crc, (tbl[i].w + 7) / 8);
      end

      // rst_n mid-byte drops busy and restores CRC-32 defaults
      cmd     = 2'd2;
      data_in = 4'h1;
      tick();
      data_in = 4'h2;
      tick();
      cmd = 2'd3;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      check("rst_mid_busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      load_check_string();
      send_msg();
      read_final(64'hFC891918, 4);

      // Nibble during busy is dropped and flags overrun; RESET clears it
      cmd     = 2'd2;
      data_in = 4'h5;
      tick();
      data_in = 4'hA;
      tick();
      data_in = 4'hF;
      tick();
      check("overrun_set", 64'(overrun), 64'd1);
      cmd = 2'd3;
      for (int c = 0; c < 20 && busy === 1'b1; c++) tick();
      check("overrun_held", 64'(overrun), 64'd1);
      msg = {8'hA5};
      exp = crc_model(32, 64'h04C11DB7, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b0, 1'b0);
      read_final(exp, 4);
      check("overrun_clear", 64'(overrun), 64'd0);

      // A pending low nibble is discarded by a non-MESSAGE command
      cmd     = 2'd2;
      data_in = 4'h3;
      tick();
      cmd = 2'd3;
      tick();
      msg = {8'h42};
      send_msg();
      exp = crc_model(32, 64'h04C11DB7, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b0, 1'b0);
      read_final(exp, 4);

      // Randomized configurations and messages
      for (int it = 0; it < 8; it++) begin
         w    = $urandom_range(3, 64);
         rp   = {$urandom, $urandom};
         ri   = {$urandom, $urandom};
         rx   = {$urandom, $urandom};
         rin  = 1'($urandom_range(0, 1));
         rout = 1'($urandom_range(0, 1));
         len  = $urandom_range(0, 5);
         do_setup(w, rp, ri, rx, rin, rout);
         check("rand_cfg_err", 64'(cfg_err), 64'd0);
         msg = {};
         for (int j = 0; j < len; j++) msg.push_back(8'($urandom));
         send_msg();
         exp = crc_model(w, rp, ri, rx, rin, rout);
         read_final(exp, (w + 7) / 8);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
